// File: rtl/except_entry_ctrl_pkg.sv
// Shared definitions for the exception entry/return controller.
// Holds:
//   - exception codes
//   - CRMD/PRMD field bit positions
//   - the sequencing FSM state type
package except_entry_ctrl_pkg;

  // Exception codes (ESTAT.Ecode encoding)
  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_PIL  = 6'h01;
  localparam logic [5:0] ECODE_PIS  = 6'h02;
  localparam logic [5:0] ECODE_PIF  = 6'h03;
  localparam logic [5:0] ECODE_PME  = 6'h04;
  localparam logic [5:0] ECODE_PPI  = 6'h07;
  localparam logic [5:0] ECODE_ADE  = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0b;
  localparam logic [5:0] ECODE_BRK  = 6'h0c;
  localparam logic [5:0] ECODE_INE  = 6'h0d;
  localparam logic [5:0] ECODE_IPE  = 6'h0e;
  localparam logic [5:0] ECODE_TLBR = 6'h3f;

  // CRMD[4:0] = {PG, DA, IE, PLV[1:0]}
  localparam int unsigned CRMD_PLV = 0;
  localparam int unsigned CRMD_IE  = 2;
  localparam int unsigned CRMD_DA  = 3;
  localparam int unsigned CRMD_PG  = 4;

  // PRMD[2:0] = {PIE, PPLV[1:0]}
  localparam int unsigned PRMD_PPLV = 0;
  localparam int unsigned PRMD_PIE  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/except_entry_ctrl_int_detect.sv
// Interrupt pending detection.
// Masks ESTAT.IS with ECFG.LIE and gates the result with CRMD.IE.
// Purely combinational; also suited to WAIT-instruction wakeup logic.
// Ports:
//   ie          - CRMD.IE
//   estat_is    - ESTAT[12:0] interrupt status
//   ecfg_lie    - local interrupt enables
//   int_pending - an enabled interrupt is pending and globally enabled
module except_entry_ctrl_int_detect (
  input  logic        ie,
  input  logic [12:0] estat_is,
  input  logic [12:0] ecfg_lie,
  output logic        int_pending
);

  assign int_pending = ie & (|(estat_is & ecfg_lie));

endmodule

// File: rtl/except_entry_ctrl.sv
// Exception/interrupt entry and ERTN return controller.
//
// Arbitrates pending interrupts against commit-stage exceptions and ERTN,
// owns CRMD[4:0], PRMD[2:0], ERA and BADV, and sequences:
//   IDLE -> FLUSH (flush + redirect pulse) -> DRAIN (wait pipe_idle) -> IDLE
//
// Ports:
//   clk, rst_n                 - clock, async active-low reset
//   commit_*                   - commit-stage handshake and event information
//   estat_is, estat_ecode,
//   ecfg_lie                   - CSR inputs from ESTAT/ECFG
//   eentry, tlbrentry          - entry vectors
//   pipe_idle                  - pipeline fully drained
//   csr_we_*, csr_wdata        - CSRWR strobes and data
//   crmd, prmd, era, badv      - owned CSR values
//   flush, redirect_vld,
//   redirect_pc                - pipeline control
//   int_taken                  - pulse in FLUSH when the event was an interrupt
//   exc_ecode                  - ecode of last entry
module except_entry_ctrl
  import except_entry_ctrl_pkg::*;
#(
  parameter logic [5:0] TLBR_ECODE = ECODE_TLBR,
  parameter logic [4:0] CRMD_RST   = 5'b01000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        commit_valid,
  output logic        commit_ready,
  input  logic [31:0] commit_pc,
  input  logic        commit_exc,
  input  logic [5:0]  commit_ecode,
  input  logic [8:0]  commit_esubcode,
  input  logic        commit_badv_vld,
  input  logic [31:0] commit_badv,
  input  logic        commit_ertn,
  input  logic [12:0] estat_is,
  input  logic [5:0]  estat_ecode,
  input  logic [12:0] ecfg_lie,
  input  logic [31:0] eentry,
  input  logic [31:0] tlbrentry,
  input  logic        pipe_idle,
  input  logic        csr_we_crmd,
  input  logic        csr_we_prmd,
  input  logic        csr_we_era,
  input  logic        csr_we_badv,
  input  logic [31:0] csr_wdata,
  output logic [4:0]  crmd,
  output logic [2:0]  prmd,
  output logic [31:0] era,
  output logic [31:0] badv,
  output logic        flush,
  output logic        redirect_vld,
  output logic [31:0] redirect_pc,
  output logic        int_taken,
  output logic [5:0]  exc_ecode
);

  state_t      state_q, state_d;
  logic        int_pending;
  logic        fire;
  logic        take_int, take_exc, take_ertn, take_entry, seq_start;
  logic [5:0]  entry_ecode;
  logic        entry_tlbr;
  logic [31:0] target_d, target_q;
  logic        int_q;
  logic [4:0]  crmd_d;
  logic [2:0]  prmd_d;
  logic [31:0] era_d, badv_d;

  // The subcode is recorded by the ESTAT owner; it is not stored here.
  logic unused_esubcode;
  assign unused_esubcode = ^commit_esubcode;

  except_entry_ctrl_int_detect u_int_detect (
    .ie          (crmd[CRMD_IE]),
    .estat_is    (estat_is),
    .ecfg_lie    (ecfg_lie),
    .int_pending (int_pending)
  );

  assign commit_ready = (state_q == ST_IDLE);
  assign fire         = commit_valid & commit_ready;

  // Priority: interrupt > exception > ERTN > plain commit
  assign take_int   = fire & int_pending;
  assign take_exc   = fire & ~int_pending & commit_exc;
  assign take_ertn  = fire & ~int_pending & ~commit_exc & commit_ertn;
  assign take_entry = take_int | take_exc;
  assign seq_start  = take_entry | take_ertn;

  assign entry_ecode = take_int ? ECODE_INT : commit_ecode;
  assign entry_tlbr  = (entry_ecode == TLBR_ECODE);

  // ERTN targets the ERA register value, not any same-cycle CSR write.
  assign target_d = take_entry ? (entry_tlbr ? tlbrentry : eentry) : era;

  // CSR writes first, then entry/ERTN overrides only the fields it touches.
  always_comb begin
    crmd_d = csr_we_crmd ? csr_wdata[4:0] : crmd;
    prmd_d = csr_we_prmd ? csr_wdata[2:0] : prmd;
    era_d  = csr_we_era  ? csr_wdata      : era;
    badv_d = csr_we_badv ? csr_wdata      : badv;

    if (take_entry) begin
      prmd_d[PRMD_PPLV +: 2] = crmd[CRMD_PLV +: 2];
      prmd_d[PRMD_PIE]       = crmd[CRMD_IE];
      crmd_d[CRMD_PLV +: 2]  = 2'b00;
      crmd_d[CRMD_IE]        = 1'b0;
      era_d                  = commit_pc;
      if (take_exc && commit_badv_vld) begin
        badv_d = commit_badv;
      end
      if (entry_tlbr) begin
        crmd_d[CRMD_DA] = 1'b1;
        crmd_d[CRMD_PG] = 1'b0;
      end
    end

    if (take_ertn) begin
      crmd_d[CRMD_PLV +: 2] = prmd[PRMD_PPLV +: 2];
      crmd_d[CRMD_IE]       = prmd[PRMD_PIE];
      if (estat_ecode == TLBR_ECODE) begin
        crmd_d[CRMD_DA] = 1'b0;
        crmd_d[CRMD_PG] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crmd      <= CRMD_RST;
      prmd      <= '0;
      era       <= '0;
      badv      <= '0;
      exc_ecode <= '0;
      target_q  <= '0;
      int_q     <= 1'b0;
    end else begin
      crmd <= crmd_d;
      prmd <= prmd_d;
      era  <= era_d;
      badv <= badv_d;
      if (take_entry) begin
        exc_ecode <= entry_ecode;
      end
      if (seq_start) begin
        target_q <= target_d;
        int_q    <= take_int;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state. DRAIN always lasts at least one cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (seq_start) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_DRAIN;
      ST_DRAIN: if (pipe_idle) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    flush        = (state_q == ST_FLUSH);
    redirect_vld = (state_q == ST_FLUSH);
    redirect_pc  = target_q;
    int_taken    = (state_q == ST_FLUSH) & int_q;
  end

endmodule

// File: tb/tb_except_entry_ctrl.sv
module tb_except_entry_ctrl;

  localparam logic [5:0] TLBR = 6'h3f;

  logic        clk;
  logic        rst_n;
  logic        commit_valid, commit_ready;
  logic [31:0] commit_pc;
  logic        commit_exc;
  logic [5:0]  commit_ecode;
  logic [8:0]  commit_esubcode;
  logic        commit_badv_vld;
  logic [31:0] commit_badv;
  logic        commit_ertn;
  logic [12:0] estat_is;
  logic [5:0]  estat_ecode;
  logic [12:0] ecfg_lie;
  logic [31:0] eentry, tlbrentry;
  logic        pipe_idle;
  logic        csr_we_crmd, csr_we_prmd, csr_we_era, csr_we_badv;
  logic [31:0] csr_wdata;
  logic [4:0]  crmd;
  logic [2:0]  prmd;
  logic [31:0] era, badv;
  logic        flush, redirect_vld;
  logic [31:0] redirect_pc;
  logic        int_taken;
  logic [5:0]  exc_ecode;

  except_entry_ctrl #(.TLBR_ECODE(6'h3f), .CRMD_RST(5'b01000)) dut (
    .clk(clk), .rst_n(rst_n),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_pc(commit_pc), .commit_exc(commit_exc),
    .commit_ecode(commit_ecode), .commit_esubcode(commit_esubcode),
    .commit_badv_vld(commit_badv_vld), .commit_badv(commit_badv),
    .commit_ertn(commit_ertn), .estat_is(estat_is),
    .estat_ecode(estat_ecode), .ecfg_lie(ecfg_lie),
    .eentry(eentry), .tlbrentry(tlbrentry), .pipe_idle(pipe_idle),
    .csr_we_crmd(csr_we_crmd), .csr_we_prmd(csr_we_prmd),
    .csr_we_era(csr_we_era), .csr_we_badv(csr_we_badv),
    .csr_wdata(csr_wdata), .crmd(crmd), .prmd(prmd), .era(era),
    .badv(badv), .flush(flush), .redirect_vld(redirect_vld),
    .redirect_pc(redirect_pc), .int_taken(int_taken),
    .exc_ecode(exc_ecode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ready;
    logic        flush;
    logic        int_tk;
    logic [4:0]  crmd;
    logic [2:0]  prmd;
    logic [31:0] era;
    logic [31:0] badv;
    logic [5:0]  ecode;
  } cyc_exp_t;

  typedef struct {
    logic [31:0] pc;
    logic        int_tk;
  } redir_t;

  cyc_exp_t cyc_q[$];
  redir_t   rd_q[$];
  int       tests = 0;
  int       fails = 0;
  bit       mon_en = 1'b0;

  // Reference architectural state, one variable per field.
  bit          m_pg, m_da, m_ie, m_pie;
  bit   [1:0]  m_plv, m_pplv;
  logic [31:0] m_era, m_badv;
  logic [5:0]  m_ecode;
  bit          m_busy;
  int          m_start;
  int          cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pg = 1'b0; m_da = 1'b1; m_ie = 1'b0; m_plv = 2'b00;
    m_pie = 1'b0; m_pplv = 2'b00;
    m_era = '0; m_badv = '0; m_ecode = '0;
    m_busy = 1'b0; m_start = 0;
  endfunction

  // Predicts the effect of the clock edge that follows the current inputs.
  function automatic void model_step();
    bit fire, pend, is_int, is_exc, is_ertn, ent;
    bit o_ie, o_pie;
    bit [1:0] o_plv, o_pplv;
    logic [31:0] o_era, tgt;
    logic [5:0] code;
    cyc_exp_t e;
    redir_t r;
    fire    = commit_valid && !m_busy;
    pend    = m_ie && ((estat_is & ecfg_lie) != 13'd0);
    is_int  = fire && pend;
    is_exc  = fire && !pend && commit_exc;
    is_ertn = fire && !pend && !commit_exc && commit_ertn;
    ent     = is_int || is_exc;
    o_ie = m_ie; o_plv = m_plv; o_pie = m_pie; o_pplv = m_pplv; o_era = m_era;
    tgt = '0;
    if (csr_we_crmd) {m_pg, m_da, m_ie, m_plv} = csr_wdata[4:0];
    if (csr_we_prmd) {m_pie, m_pplv} = csr_wdata[2:0];
    if (csr_we_era)  m_era = csr_wdata;
    if (csr_we_badv) m_badv = csr_wdata;
    if (ent) begin
      m_pplv = o_plv; m_pie = o_ie; m_plv = 2'b00; m_ie = 1'b0;
      m_era = commit_pc;
      if (is_exc && commit_badv_vld) m_badv = commit_badv;
      code = is_int ? 6'h00 : commit_ecode;
      m_ecode = code;
      if (code == TLBR) begin
        m_da = 1'b1; m_pg = 1'b0; tgt = tlbrentry;
      end else begin
        tgt = eentry;
      end
    end
    if (is_ertn) begin
      m_plv = o_pplv; m_ie = o_pie;
      if (estat_ecode == TLBR) begin
        m_da = 1'b0; m_pg = 1'b1;
      end
      tgt = o_era;
    end
    // A sequence spans the flush cycle plus at least one drain cycle.
    if (m_busy && cyc >= m_start + 2 && pipe_idle) m_busy = 1'b0;
    if (ent || is_ertn) begin
      m_busy = 1'b1; m_start = cyc;
      r.pc = tgt; r.int_tk = is_int;
      rd_q.push_back(r);
    end
    e.ready  = !m_busy;
    e.flush  = ent || is_ertn;
    e.int_tk = is_int;
    e.crmd   = {m_pg, m_da, m_ie, m_plv};
    e.prmd   = {m_pie, m_pplv};
    e.era    = m_era;
    e.badv   = m_badv;
    e.ecode  = m_ecode;
    cyc_q.push_back(e);
    cyc++;
  endfunction

  task automatic step();
    model_step();
    @(negedge clk);
  endtask

  task automatic clr();
    commit_valid = 1'b0; commit_exc = 1'b0; commit_ertn = 1'b0;
    commit_badv_vld = 1'b0; commit_ecode = '0; commit_esubcode = '0;
    csr_we_crmd = 1'b0; csr_we_prmd = 1'b0; csr_we_era = 1'b0; csr_we_badv = 1'b0;
    estat_is = '0; pipe_idle = 1'b1;
  endtask

  task automatic drain();
    clr();
    for (int k = 0; k < 20 && m_busy; k++) step();
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".crmd"},      32'(crmd), 32'h08);
    check({tag, ".prmd"},      32'(prmd), 32'h0);
    check({tag, ".era"},       era, 32'h0);
    check({tag, ".badv"},      badv, 32'h0);
    check({tag, ".flush"},     32'(flush), 32'h0);
    check({tag, ".redir"},     32'(redirect_vld), 32'h0);
    check({tag, ".int_taken"}, 32'(int_taken), 32'h0);
    check({tag, ".ecode"},     32'(exc_ecode), 32'h0);
    check({tag, ".ready"},     32'(commit_ready), 32'h1);
  endtask

  // Monitor: per-cycle expectations, plus redirect scoreboard on redirect_vld.
  initial begin
    cyc_exp_t e;
    redir_t r;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (cyc_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL cyc_queue: got empty expected entry (t=%0t)", $time);
        end else begin
          e = cyc_q.pop_front();
          check("commit_ready", 32'(commit_ready), 32'(e.ready));
          check("flush",        32'(flush),        32'(e.flush));
          check("redirect_vld", 32'(redirect_vld), 32'(e.flush));
          check("int_taken",    32'(int_taken),    32'(e.int_tk));
          check("crmd",         32'(crmd),         32'(e.crmd));
          check("prmd",         32'(prmd),         32'(e.prmd));
          check("era",          era,               e.era);
          check("badv",         badv,              e.badv);
          check("exc_ecode",    32'(exc_ecode),    32'(e.ecode));
        end
        if (redirect_vld) begin
          if (rd_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL redirect_queue: got unexpected redirect to %h expected none", redirect_pc);
          end else begin
            r = rd_q.pop_front();
            check("redirect_pc", redirect_pc, r.pc);
            check("redirect_int", 32'(int_taken), 32'(r.int_tk));
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    clr();
    commit_pc = '0; commit_badv = '0; csr_wdata = '0;
    estat_ecode = '0; ecfg_lie = '0;
    eentry = 32'h1c008000; tlbrentry = 32'h1c00f000;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Interrupt entry from PLV3 with IE=1
    csr_we_crmd = 1'b1; csr_wdata = 32'h0f; step(); clr();
    estat_is = 13'h800; ecfg_lie = 13'h800;
    commit_valid = 1'b1; commit_pc = 32'h1c000100;
    step();
    check("int.flush",  32'(flush), 32'h1);
    check("int.pc",     redirect_pc, 32'h1c008000);
    check("int.taken",  32'(int_taken), 32'h1);
    check("int.era",    era, 32'h1c000100);
    check("int.prmd",   32'(prmd), 32'h7);
    check("int.crmd",   32'(crmd), 32'h08);
    check("int.ecode",  32'(exc_ecode), 32'h0);
    drain();

    // Masked interrupt: LIE clear, then IE clear
    csr_we_crmd = 1'b1; csr_wdata = 32'h0c; step(); clr();
    estat_is = 13'h004; ecfg_lie = 13'h000; commit_valid = 1'b1; commit_pc = 32'h1c000104;
    step();
    check("mask_lie.flush", 32'(flush), 32'h0);
    clr();
    csr_we_crmd = 1'b1; csr_wdata = 32'h08; step(); clr();
    estat_is = 13'h004; ecfg_lie = 13'h004; commit_valid = 1'b1;
    step();
    check("mask_ie.flush", 32'(flush), 32'h0);
    clr(); ecfg_lie = '0;

    // TLB refill exception
    commit_valid = 1'b1; commit_exc = 1'b1; commit_ecode = 6'h3f;
    commit_badv_vld = 1'b1; commit_badv = 32'hdeadbeef; commit_pc = 32'h1c000200;
    step();
    check("tlbr.pc",    redirect_pc, 32'h1c00f000);
    check("tlbr.badv",  badv, 32'hdeadbeef);
    check("tlbr.dapg",  32'(crmd[4:3]), 32'h1);
    drain();

    // ERTN out of TLB refill
    csr_we_prmd = 1'b1; csr_wdata = 32'h4; step(); clr();
    estat_ecode = 6'h3f; commit_valid = 1'b1; commit_ertn = 1'b1;
    step();
    check("ertn.pc",   redirect_pc, 32'h1c000200);
    check("ertn.crmd", 32'(crmd), 32'h14);
    drain();
    estat_ecode = '0;

    // Interrupt vs exception vs CRMD write in one cycle
    estat_is = 13'h800; ecfg_lie = 13'h800;
    commit_valid = 1'b1; commit_exc = 1'b1; commit_ecode = 6'h0b;
    csr_we_crmd = 1'b1; csr_wdata = 32'h1f;
    step();
    check("coll.ecode", 32'(exc_ecode), 32'h0);
    check("coll.int",   32'(int_taken), 32'h1);
    check("coll.crmd",  32'(crmd), 32'h18);
    drain();
    ecfg_lie = '0;

    // Long drain, then reset while draining
    commit_valid = 1'b1; commit_exc = 1'b1; commit_ecode = 6'h0b; commit_pc = 32'h1c000300;
    step(); clr(); pipe_idle = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("drain.ready", 32'(commit_ready), 32'h0);
    end
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    rd_q.delete();
    mon_en = 1'b1;
    clr();
    step();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      commit_valid    = ($urandom_range(0, 1) == 1);
      commit_exc      = ($urandom_range(0, 3) == 0);
      commit_ertn     = ($urandom_range(0, 3) == 0);
      commit_ecode    = ($urandom_range(0, 3) == 0) ? 6'h3f : 6'($urandom_range(0, 63));
      commit_esubcode = 9'($urandom);
      commit_badv_vld = ($urandom_range(0, 1) == 1);
      commit_badv     = $urandom;
      commit_pc       = $urandom;
      estat_is        = ($urandom_range(0, 2) == 0) ? 13'(1 << $urandom_range(0, 12)) : 13'd0;
      ecfg_lie        = 13'($urandom);
      estat_ecode     = ($urandom_range(0, 1) == 1) ? 6'h3f : 6'($urandom_range(0, 63));
      pipe_idle       = ($urandom_range(0, 2) != 0);
      csr_we_crmd     = ($urandom_range(0, 7) == 0);
      csr_we_prmd     = ($urandom_range(0, 7) == 0);
      csr_we_era      = ($urandom_range(0, 9) == 0);
      csr_we_badv     = ($urandom_range(0, 9) == 0);
      csr_wdata       = $urandom;
      step();
    end
    drain();
    step();
    mon_en = 1'b0;
    check("redirect_queue_empty", 32'(rd_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
